sha256_round_ctrl: RTL and testbench

Sequencer for the single-round SHA-256 compression datapath. It accepts one 512-bit padded message block per transaction and loads the datapath's a..h registers with the chaining value. It then drives 64 rounds of W_t/K_t from an internal message-schedule window and constant ROM. Finally it adds the working state to the chaining value and presents the 256-bit digest on a valid/ready output. It sits between the block-assembly front end and the hash-compare logic of the miner.

---
 rtl/sha256_pkg.sv | 58 +++++
 rtl/sha256_msg_sched.sv | 35 +++
 rtl/sha256_round_ctrl.sv | 121 ++++++++++++
 tb/tb_sha256_round_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller states, round constants, IV and word helpers.
package sha256_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRound,
    StFinal,
    StDone
  } state_t;

  localparam logic [255:0] ShaIv =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] RoundK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Message-schedule small sigma functions (right rotates).
  function automatic logic [31:0] sigma0(logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Word i of a 512-bit block, word 0 in the top bits.
  function automatic logic [31:0] blk_word(logic [511:0] b, int i);
    return b[32*(15-i) +: 32];
  endfunction

  // Per-word modulo-2^32 add of two packed {a..h} states; no carry crosses words.
  function automatic logic [255:0] add_state(logic [255:0] x, logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word SHA-256 message-schedule window; win[0] is W_t for the current round.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] blk,
  output logic [31:0]  w0
);

  logic [31:0] win [16];
  logic [31:0] w_next;

  // W_{t+16} from the current window contents.
  always_comb begin
    w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  end

  // Parallel load on block acceptance, shift down one word per round.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= blk_word(blk, i);
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_next;
    end
  end

  assign w0 = win[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: loads the datapath, drives 64 rounds, adds the chaining value.
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  output logic         dp_load,
  output logic [255:0] dp_init,
  output logic         dp_en,
  output logic [31:0]  dp_w,
  output logic [31:0]  dp_k,
  input  logic [255:0] dp_state,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
  output logic         busy
);

  state_t       state;
  logic         first_q;
  logic [5:0]   rnd;
  logic [255:0] h_q;
  logic [255:0] h_in_q;
  logic [255:0] digest_q;
  logic         busy_q;
  logic         dp_load_q;
  logic         dp_en_q;
  logic         dig_valid_q;
  logic         accept;
  logic [31:0]  win0;

  assign accept = blk_valid & blk_ready;

  sha256_msg_sched u_msg_sched (
    .clk   (clk),
    .n_rst (n_rst),
    .load  (accept),
    .shift (dp_en_q),
    .blk   (blk_data),
    .w0    (win0)
  );

  // Datapath-facing values are zero whenever the datapath is not being driven.
  always_comb begin
    dp_init = '0;
    dp_w    = '0;
    dp_k    = '0;
    if (dp_load_q) dp_init = first_q ? ShaIv : h_q;
    if (dp_en_q) begin
      dp_w = win0;
      dp_k = RoundK[rnd];
    end
  end

  assign blk_ready = ~busy_q;
  assign busy      = busy_q;
  assign dp_load   = dp_load_q;
  assign dp_en     = dp_en_q;
  assign dig_valid = dig_valid_q;
  assign digest    = digest_q;

  // Transaction FSM with registered strobes; chain H persists between blocks.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= StIdle;
      first_q     <= 1'b0;
      rnd         <= '0;
      h_q         <= ShaIv;
      h_in_q      <= '0;
      digest_q    <= '0;
      busy_q      <= 1'b0;
      dp_load_q   <= 1'b0;
      dp_en_q     <= 1'b0;
      dig_valid_q <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            first_q   <= blk_first;
            busy_q    <= 1'b1;
            dp_load_q <= 1'b1;
            state     <= StLoad;
          end
        end
        StLoad: begin
          h_in_q    <= dp_init;
          rnd       <= '0;
          dp_load_q <= 1'b0;
          dp_en_q   <= 1'b1;
          state     <= StRound;
        end
        StRound: begin
          rnd <= rnd + 6'd1;
          if (rnd == 6'd63) begin
            dp_en_q <= 1'b0;
            state   <= StFinal;
          end
        end
        StFinal: begin
          h_q         <= add_state(h_in_q, dp_state);
          digest_q    <= add_state(h_in_q, dp_state);
          dig_valid_q <= 1'b1;
          state       <= StDone;
        end
        StDone: begin
          if (dig_ready) begin
            dig_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl with a behavioural round datapath and SHA-256 model.
module tb_sha256_round_ctrl;

  localparam logic [255:0] Iv =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] Tk [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BlkAbc = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BlkEmpty = {32'h80000000, 480'h0};
  localparam logic [511:0] BlkLong1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BlkLong2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] DigAbc =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DigEmpty =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DigLong =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         dp_load;
  logic [255:0] dp_init;
  logic         dp_en;
  logic [31:0]  dp_w;
  logic [31:0]  dp_k;
  logic [255:0] dp_state = '0;
  logic         dig_valid;
  logic         dig_ready = 1'b1;
  logic [255:0] digest;
  logic         busy;

  sha256_round_ctrl dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .dp_load   (dp_load),
    .dp_init   (dp_init),
    .dp_en     (dp_en),
    .dp_w      (dp_w),
    .dp_k      (dp_k),
    .dp_state  (dp_state),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .digest    (digest),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference SHA-256 math ----------------
  function automatic logic [31:0] ror(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] one_round(logic [255:0] s, logic [31:0] w, logic [31:0] k);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    for (int i = 0; i < 8; i++) v[i] = s[255-32*i -: 32];
    t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) +
         ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
    t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) +
         ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    return {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
  endfunction

  function automatic void expand(input logic [511:0] blk, output logic [31:0] w [64]);
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
  endfunction

  function automatic logic [255:0] compress(logic [255:0] hin, logic [511:0] blk);
    logic [31:0]  w [64];
    logic [255:0] s;
    logic [255:0] r;
    expand(blk, w);
    s = hin;
    for (int t = 0; t < 64; t++) s = one_round(s, w[t], Tk[t]);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = hin[32*i +: 32] + s[32*i +: 32];
    return r;
  endfunction

  // External round datapath driven by the controller.
  always @(posedge clk) begin
    if (dp_load) dp_state <= dp_init;
    else if (dp_en) dp_state <= one_round(dp_state, dp_w, dp_k);
  end

  // ---------------- scoreboard ----------------
  logic [255:0] exp_dig [$];
  time          exp_t0 [$];
  logic [63:0]  exp_wk [$];
  logic [255:0] chain_ref = Iv;
  logic [255:0] cur_exp = '0;
  logic [255:0] last_dig = '0;
  time          cur_t0 = 0;
  logic         seen_valid = 1'b0;
  int           hold_bad = 0;
  int           overlap = 0;
  int           idle_nonzero = 0;
  logic         hold_low = 1'b0;
  logic         rand_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    if (hold_low) dig_ready = 1'b0;
    else if (rand_ready) dig_ready = 1'($urandom_range(0, 1));
    else dig_ready = 1'b1;
  end

  // Monitor: pops expected round inputs and digests as the DUT presents them.
  always @(negedge clk) begin
    logic [63:0] e;
    if (n_rst) begin
      if (dp_load && dp_en) overlap++;
      if (dp_en) begin
        if (exp_wk.size() == 0) begin
          check("round_unexpected", 256'(dp_en), 256'(0));
        end else begin
          e = exp_wk.pop_front();
          check("dp_w", 256'(dp_w), 256'(e[63:32]));
          check("dp_k", 256'(dp_k), 256'(e[31:0]));
        end
      end else if (dp_w !== 32'h0 || dp_k !== 32'h0) begin
        idle_nonzero++;
      end
      if (dig_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          if (exp_dig.size() == 0) begin
            check("digest_unexpected", 256'(dig_valid), 256'(0));
            cur_exp = digest;
          end else begin
            cur_exp = exp_dig.pop_front();
            cur_t0  = exp_t0.pop_front();
            check("latency", 256'($time - cur_t0), 256'(665));
            check("digest", digest, cur_exp);
          end
        end else if (digest !== cur_exp || blk_ready !== 1'b0) begin
          hold_bad++;
        end
        if (dig_ready) begin
          seen_valid = 1'b0;
          last_dig   = digest;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [511:0] blk, input logic first);
    logic [31:0]  w [64];
    logic [255:0] hs;
    int n;
    @(negedge clk);
    blk_valid = 1'b1;
    blk_data  = blk;
    blk_first = first;
    n = 0;
    while (!blk_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!blk_ready) begin
      check("accept_timeout", 256'(blk_ready), 256'(1));
      blk_valid = 1'b0;
      return;
    end
    @(posedge clk);
    hs = first ? Iv : chain_ref;
    chain_ref = compress(hs, blk);
    expand(blk, w);
    exp_dig.push_back(chain_ref);
    exp_t0.push_back($time);
    for (int t = 0; t < 64; t++) exp_wk.push_back({w[t], Tk[t]});
    #1 blk_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_dig.size() != 0 || busy || seen_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("idle_timeout", 256'(busy), 256'(0));
  endtask

  task automatic check_reset(string tag);
    check({tag, "_flags"}, 256'({blk_ready, busy, dp_load, dp_en, dig_valid}), 256'(5'b10000));
    check({tag, "_dp_w"}, 256'(dp_w), 256'(0));
    check({tag, "_dp_k"}, 256'(dp_k), 256'(0));
    check({tag, "_dp_init"}, dp_init, 256'(0));
    check({tag, "_digest"}, digest, 256'(0));
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset("rst_init");
    n_rst = 1'b1;

    send(BlkAbc, 1'b1);
    wait_idle();
    check("abc_digest", last_dig, DigAbc);

    send(BlkEmpty, 1'b1);
    wait_idle();
    check("empty_digest", last_dig, DigEmpty);

    send(BlkLong1, 1'b1);
    send(BlkLong2, 1'b0);
    wait_idle();
    check("two_block_digest", last_dig, DigLong);

    // Random blocks, random first flag, random consumer back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(rand_blk(), 1'($urandom_range(0, 1)));
    wait_idle();
    rand_ready = 1'b0;

    // Hold the digest for 10 cycles while offering stray blocks.
    hold_low = 1'b1;
    send(rand_blk(), 1'b0);
    n = 0;
    while (!dig_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid", 256'(dig_valid), 256'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      blk_valid = (i >= 2 && i <= 5);
      blk_data  = rand_blk();
    end
    blk_valid = 1'b0;
    check("hold_blk_ready", 256'(blk_ready), 256'(0));
    check("hold_dig_valid", 256'(dig_valid), 256'(1));
    hold_low = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    check("no_extra_txn", 256'({busy, dig_valid}), 256'(0));

    // Abort mid-block at round 30; chain must fall back to IV.
    send(rand_blk(), 1'b1);
    n = 0;
    while (!dp_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    #2 n_rst = 1'b0;
    exp_dig.delete();
    exp_t0.delete();
    exp_wk.delete();
    seen_valid = 1'b0;
    chain_ref  = Iv;
    #1 check_reset("rst_mid");
    @(negedge clk);
    @(negedge clk);
    check_reset("rst_hold");
    n_rst = 1'b1;
    send(BlkAbc, 1'b0);
    wait_idle();
    check("abc_after_reset", last_dig, DigAbc);

    check("load_en_overlap", 256'(overlap), 256'(0));
    check("idle_wk_zero", 256'(idle_nonzero), 256'(0));
    check("hold_stable", 256'(hold_bad), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
